// File: rtl/qspi_line_reader_if.sv
// qspi_line_reader_if: request/response bundle between the flash cache
// line-refill logic (master) and qspi_line_reader (slave).
//   addr   : byte address of the line, sampled when rd is accepted
//   rd     : request pulse, accepted only while busy is low
//   xip_en : 1 keeps the flash in continuous-read mode after this fetch
//   busy   : fetcher is working (transaction or chip-select gap)
//   done   : one-cycle pulse, line valid in that cycle
//   line   : fetched line, byte k of the fetch in line[8k+7:8k]
interface qspi_line_reader_if #(
  parameter int LINE_SIZE = 128
);
  logic [23:0]          addr;
  logic                 rd;
  logic                 xip_en;
  logic                 busy;
  logic                 done;
  logic [LINE_SIZE-1:0] line;

  modport master (output addr, rd, xip_en, input busy, done, line);
  modport slave  (input addr, rd, xip_en, output busy, done, line);
endinterface

// File: rtl/qspi_line_reader.sv
// qspi_line_reader: fetches one LINE_SIZE-bit line per request from a quad-I/O
// flash using Fast Read Quad I/O (0xEB), with runtime continuous-read entry/exit.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request/response bundle (addr, rd, xip_en -> busy, done, line)
//   sck_o     : flash clock, idle low, low half of every period first
//   ce_n_o    : flash chip select, active low
//   din_i     : IO[3:0] from the flash
//   dout_o    : IO[3:0] to the flash
//   douten_o  : per-lane output enable, 1 = drive
module qspi_line_reader #(
  parameter int LINE_SIZE    = 128,
  parameter int CLK_DIV      = 1,
  parameter int DUMMY_CYCLES = 4,
  parameter int CS_HIGH      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  qspi_line_reader_if.slave    req,
  output logic                 sck_o,
  output logic                 ce_n_o,
  input  logic [3:0]           din_i,
  output logic [3:0]           dout_o,
  output logic [3:0]           douten_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_MODE  = 3'd3,
    S_DUMMY = 3'd4,
    S_DATA  = 3'd5,
    S_GAP   = 3'd6
  } state_e;

  localparam int         NIB_W      = $clog2(LINE_SIZE / 4);
  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [7:0] CMD_LAST   = 8'd7;
  localparam logic [7:0] ADDR_LAST  = 8'd5;
  localparam logic [7:0] MODE_LAST  = 8'd1;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] DATA_LAST  = 8'(LINE_SIZE / 4 - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_HIGH - 1);
  localparam logic [7:0] FAST_READ  = 8'hEB;
  localparam logic [7:0] MODE_STAY  = 8'hA5;
  localparam logic [7:0] MODE_EXIT  = 8'hFF;

  state_e               state_q, state_d;
  logic [3:0]           div_q, div_d;      // clk count inside an SCK half
  logic [7:0]           cyc_q, cyc_d;      // SCK cycle inside a phase, or gap clk count
  logic                 sck_q, sck_d;
  logic                 ce_n_q, ce_n_d;
  logic [3:0]           dout_q, dout_d;
  logic [3:0]           douten_q, douten_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [LINE_SIZE-1:0] line_q, line_d;
  logic                 cont_q, cont_d;    // flash is in continuous-read mode
  logic [23:0]          addr_q, addr_d;
  logic [7:0]           mode_q, mode_d;

  state_e               start_st_s, nxt_state_s;
  logic [7:0]           nxt_cyc_s, phase_last_s, drv_s;
  logic [NIB_W-1:0]     nib_idx_s;

  // Lane drive for SCK cycle idx of phase st: {douten, dout}.
  function automatic logic [7:0] lane_drive(input state_e st, input logic [7:0] idx,
                                            input logic [23:0] a, input logic [7:0] m);
    logic [7:0]  r;
    logic [7:0]  csh;
    logic [23:0] ash;
    logic [7:0]  msh;
    r   = 8'h00;
    csh = FAST_READ << idx[2:0];
    ash = a << {idx[2:0], 2'b00};
    msh = m << {idx[0], 2'b00};
    case (st)
      S_CMD:   r = {4'b0001, 3'b000, csh[7]};
      S_ADDR:  r = {4'hF, ash[23:20]};
      S_MODE:  r = {4'hF, msh[7:4]};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Next-state, SCK generation, lane drive and data capture.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cyc_d        = cyc_q;
    sck_d        = sck_q;
    ce_n_d       = ce_n_q;
    dout_d       = dout_q;
    douten_d     = douten_q;
    done_d       = 1'b0;
    line_d       = line_q;
    cont_d       = cont_q;
    addr_d       = addr_q;
    mode_d       = mode_q;
    start_st_s   = cont_q ? S_ADDR : S_CMD;
    nxt_state_s  = state_q;
    nxt_cyc_s    = cyc_q;
    drv_s        = 8'h00;
    nib_idx_s    = cyc_q[NIB_W-1:0];
    nib_idx_s[0] = ~nib_idx_s[0];  // high nibble of each byte arrives first

    case (state_q)
      S_CMD:   phase_last_s = CMD_LAST;
      S_ADDR:  phase_last_s = ADDR_LAST;
      S_MODE:  phase_last_s = MODE_LAST;
      S_DUMMY: phase_last_s = DUMMY_LAST;
      S_DATA:  phase_last_s = DATA_LAST;
      default: phase_last_s = GAP_LAST;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req.rd) begin
          addr_d   = req.addr;
          mode_d   = req.xip_en ? MODE_STAY : MODE_EXIT;
          state_d  = start_st_s;
          cyc_d    = 8'd0;
          div_d    = 4'd0;
          sck_d    = 1'b0;
          ce_n_d   = 1'b0;
          drv_s    = lane_drive(start_st_s, 8'd0, req.addr, mode_d);
          douten_d = drv_s[7:4];
          dout_d   = drv_s[3:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 4'd1;
        end else if (!sck_q) begin
          div_d = 4'd0;
          sck_d = 1'b1;
        end else begin
          // Last clk of a high half: sample din, close this SCK cycle and
          // present the next cycle's lane values for the coming low half.
          div_d = 4'd0;
          sck_d = 1'b0;
          if (state_q == S_DATA) begin
            line_d[{nib_idx_s, 2'b00} +: 4] = din_i;
          end else begin
            line_d = line_q;
          end
          if (cyc_q != phase_last_s) begin
            nxt_cyc_s = cyc_q + 8'd1;
          end else begin
            nxt_cyc_s = 8'd0;
            case (state_q)
              S_CMD:   nxt_state_s = S_ADDR;
              S_ADDR:  nxt_state_s = S_MODE;
              S_MODE:  nxt_state_s = (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
              S_DUMMY: nxt_state_s = S_DATA;
              S_DATA:  nxt_state_s = S_GAP;
              default: nxt_state_s = S_IDLE;
            endcase
          end
          state_d = nxt_state_s;
          cyc_d   = nxt_cyc_s;
          if (nxt_state_s == S_GAP) begin
            ce_n_d   = 1'b1;
            done_d   = 1'b1;
            cont_d   = (mode_q == MODE_STAY);
            dout_d   = 4'h0;
            douten_d = 4'h0;
          end else begin
            drv_s    = lane_drive(nxt_state_s, nxt_cyc_s, addr_q, mode_q);
            douten_d = drv_s[7:4];
            dout_d   = drv_s[3:0];
          end
        end
      end
      S_GAP: begin
        if (cyc_q == GAP_LAST) begin
          state_d = S_IDLE;
          cyc_d   = 8'd0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: begin
        // Unreachable encoding: park safely with the flash deselected.
        state_d  = S_IDLE;
        ce_n_d   = 1'b1;
        sck_d    = 1'b0;
        douten_d = 4'h0;
        dout_d   = 4'h0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= 4'd0;
      cyc_q    <= 8'd0;
      sck_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      dout_q   <= 4'h0;
      douten_q <= 4'h0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      line_q   <= {LINE_SIZE{1'b0}};
      cont_q   <= 1'b0;
      addr_q   <= 24'h000000;
      mode_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cyc_q    <= cyc_d;
      sck_q    <= sck_d;
      ce_n_q   <= ce_n_d;
      dout_q   <= dout_d;
      douten_q <= douten_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      line_q   <= line_d;
      cont_q   <= cont_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
    end
  end

  assign sck_o    = sck_q;
  assign ce_n_o   = ce_n_q;
  assign dout_o   = dout_q;
  assign douten_o = douten_q;
  assign req.busy = busy_q;
  assign req.done = done_q;
  assign req.line = line_q;

endmodule

// File: tb/tb_qspi_line_reader.sv
module tb_qspi_line_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // DUT 1: default parameters, driven by a behavioural flash model
  qspi_line_reader_if #(.LINE_SIZE(128)) bus ();
  logic       sck1, ce_n1;
  logic [3:0] din1, dout1, douten1;
  qspi_line_reader #(.LINE_SIZE(128), .CLK_DIV(1), .DUMMY_CYCLES(4), .CS_HIGH(2)) dut (
    .clk(clk), .rst(rst), .req(bus.slave), .sck_o(sck1), .ce_n_o(ce_n1),
    .din_i(din1), .dout_o(dout1), .douten_o(douten1));

  // DUT 2: slow SCK, long line, constant data nibble
  qspi_line_reader_if #(.LINE_SIZE(256)) bus2 ();
  logic       sck2, ce_n2;
  logic [3:0] dout2, douten2;
  logic [3:0] din2 = 4'h6;
  qspi_line_reader #(.LINE_SIZE(256), .CLK_DIV(2), .DUMMY_CYCLES(6), .CS_HIGH(2)) dut2 (
    .clk(clk), .rst(rst), .req(bus2.slave), .sck_o(sck2), .ce_n_o(ce_n2),
    .din_i(din2), .dout_o(dout2), .douten_o(douten2));

  // Flash model state (byte at address a holds a[7:0])
  int          f_edge = 0;
  int          f_oe_err = 0;
  logic        f_cont = 1'b0, f_cont_next = 1'b0, f_had_cmd = 1'b0, f_mode_done = 1'b0;
  logic [7:0]  f_cmd = 8'h00, f_mode = 8'h00;
  logic [23:0] f_addr = 24'h000000;

  initial begin : flash_model
    int          off, d;
    logic [23:0] ba;
    logic        ce_prev;
    ce_prev = 1'b1;
    din1    = 4'h0;
    forever begin
      @(posedge sck1 or negedge ce_n1 or posedge ce_n1);
      if (ce_n1 !== ce_prev) begin
        ce_prev = ce_n1;
        if (ce_n1 === 1'b0) begin
          f_edge = 0; f_had_cmd = !f_cont; f_mode_done = 1'b0;
          f_cmd = 8'h00; f_addr = 24'h000000; f_mode = 8'h00; din1 = 4'h0;
        end else if (f_mode_done) begin
          f_cont = f_cont_next;
        end
      end else if (sck1 === 1'b1 && ce_n1 === 1'b0) begin
        off = f_had_cmd ? 8 : 0;
        if (f_edge < off) begin
          f_cmd = {f_cmd[6:0], dout1[0]};
          if (douten1 !== 4'b0001 || dout1[3:1] !== 3'b000) f_oe_err++;
        end else if (f_edge < off + 6) begin
          f_addr = {f_addr[19:0], dout1};
          if (douten1 !== 4'hF) f_oe_err++;
        end else if (f_edge < off + 8) begin
          f_mode = {f_mode[3:0], dout1};
          if (douten1 !== 4'hF) f_oe_err++;
          if (f_edge == off + 7) begin
            f_mode_done = 1'b1;
            f_cont_next = (f_mode == 8'hA5);
          end
        end else begin
          if (douten1 !== 4'h0) f_oe_err++;
          if (f_edge >= off + 8 + 4) begin
            d    = f_edge - off - 12;
            ba   = f_addr + 24'(d / 2);
            din1 = (d % 2 == 0) ? ba[7:4] : ba[3:0];
          end
        end
        f_edge++;
      end
    end
  end

  // Shortest ce_n high stretch between two transactions of DUT 1
  int min_gap = 1000;
  initial begin : gap_monitor
    int   hi_run;
    logic seen_low;
    hi_run = 0; seen_low = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        hi_run = 0; seen_low = 1'b0;
      end else if (ce_n1 === 1'b1) begin
        hi_run++;
      end else begin
        if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0; seen_low = 1'b1;
      end
    end
  end

  function automatic logic [127:0] exp_line(input logic [23:0] a);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = a[7:0] + 8'(k);
    return r;
  endfunction

  // Issue one read on DUT 1 (called at posedge+1 while idle) and time it.
  task automatic run_read(input logic [23:0] a, input logic x,
                          output int dcyc, output int bdrop, output int ce1, output int cerise);
    bus.addr = a; bus.xip_en = x; bus.rd = 1'b1;
    @(posedge clk); #1;
    bus.rd = 1'b0;
    dcyc = -1; bdrop = -1; cerise = -1; ce1 = int'(ce_n1);
    for (int k = 1; k < 3000; k++) begin
      if (cerise < 0 && ce_n1 === 1'b1) cerise = k;
      if (dcyc < 0 && bus.done === 1'b1) dcyc = k;
      if (bus.busy === 1'b0) begin bdrop = k; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (sck1 !== 1'b0) begin n_err++; $display("FAIL reset_sck: got %b want 0", sck1); end
    n_vec++; if (ce_n1 !== 1'b1) begin n_err++; $display("FAIL reset_ce_n: got %b want 1", ce_n1); end
    n_vec++; if (dout1 !== 4'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", dout1); end
    n_vec++; if (douten1 !== 4'h0) begin n_err++; $display("FAIL reset_douten: got %h want 0", douten1); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.line !== 128'h0) begin n_err++; $display("FAIL reset_line: got %h want 0", bus.line); end
    n_vec++; if (dut.cont_q !== 1'b0) begin n_err++; $display("FAIL reset_cont: got %b want 0", dut.cont_q); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_first_read();
    int dc, bd, c1, cr;
    run_read(24'h000100, 1'b1, dc, bd, c1, cr);
    n_vec++; if (dc !== 105) begin n_err++; $display("FAIL first_done_cycle: got %0d want 105", dc); end
    n_vec++; if (bd !== 107) begin n_err++; $display("FAIL first_busy_drop: got %0d want 107", bd); end
    n_vec++; if (c1 !== 0) begin n_err++; $display("FAIL first_ce_low_cycle1: got %0d want 0", c1); end
    n_vec++; if (cr !== 105) begin n_err++; $display("FAIL first_ce_rise: got %0d want 105", cr); end
    n_vec++; if (f_had_cmd !== 1'b1) begin n_err++; $display("FAIL first_cmd_phase: got %b want 1", f_had_cmd); end
    n_vec++; if (f_cmd !== 8'hEB) begin n_err++; $display("FAIL first_cmd_bits: got %h want eb", f_cmd); end
    n_vec++; if (f_addr !== 24'h000100) begin n_err++; $display("FAIL first_addr: got %h want 000100", f_addr); end
    n_vec++; if (f_mode !== 8'hA5) begin n_err++; $display("FAIL first_mode: got %h want a5", f_mode); end
    n_vec++; if (bus.line[7:0] !== 8'h00) begin n_err++; $display("FAIL first_byte0: got %h want 00", bus.line[7:0]); end
    n_vec++; if (bus.line[127:120] !== 8'h0F) begin n_err++; $display("FAIL first_byte15: got %h want 0f", bus.line[127:120]); end
    n_vec++; if (bus.line !== exp_line(24'h000100)) begin n_err++; $display("FAIL first_line: got %h want %h", bus.line, exp_line(24'h000100)); end
    n_vec++; if (dut.cont_q !== 1'b1) begin n_err++; $display("FAIL first_cont: got %b want 1", dut.cont_q); end
  endtask

  task automatic test_xip_read();
    int dc, bd, c1, cr;
    run_read(24'h000200, 1'b1, dc, bd, c1, cr);
    n_vec++; if (dc !== 89) begin n_err++; $display("FAIL xip_done_cycle: got %0d want 89", dc); end
    n_vec++; if (bd !== 91) begin n_err++; $display("FAIL xip_busy_drop: got %0d want 91", bd); end
    n_vec++; if (f_had_cmd !== 1'b0) begin n_err++; $display("FAIL xip_cmd_phase: got %b want 0", f_had_cmd); end
    n_vec++; if (f_addr !== 24'h000200) begin n_err++; $display("FAIL xip_addr: got %h want 000200", f_addr); end
    n_vec++; if (bus.line[7:0] !== 8'h00) begin n_err++; $display("FAIL xip_byte0: got %h want 00", bus.line[7:0]); end
    n_vec++; if (bus.line !== exp_line(24'h000200)) begin n_err++; $display("FAIL xip_line: got %h want %h", bus.line, exp_line(24'h000200)); end
  endtask

  task automatic test_xip_exit();
    int dc, bd, c1, cr;
    run_read(24'h000345, 1'b0, dc, bd, c1, cr);
    n_vec++; if (dc !== 89) begin n_err++; $display("FAIL exit_done_cycle: got %0d want 89", dc); end
    n_vec++; if (f_had_cmd !== 1'b0) begin n_err++; $display("FAIL exit_cmd_phase: got %b want 0", f_had_cmd); end
    n_vec++; if (f_mode !== 8'hFF) begin n_err++; $display("FAIL exit_mode: got %h want ff", f_mode); end
    n_vec++; if (dut.cont_q !== 1'b0) begin n_err++; $display("FAIL exit_cont: got %b want 0", dut.cont_q); end
    n_vec++; if (bus.line !== exp_line(24'h000345)) begin n_err++; $display("FAIL exit_line: got %h want %h", bus.line, exp_line(24'h000345)); end
  endtask

  task automatic test_full_cmd_again();
    int dc, bd, c1, cr;
    run_read(24'h123456, 1'b1, dc, bd, c1, cr);
    n_vec++; if (dc !== 105) begin n_err++; $display("FAIL again_done_cycle: got %0d want 105", dc); end
    n_vec++; if (f_had_cmd !== 1'b1 || f_cmd !== 8'hEB) begin n_err++; $display("FAIL again_cmd: got phase=%b cmd=%h want 1/eb", f_had_cmd, f_cmd); end
    n_vec++; if (f_addr !== 24'h123456) begin n_err++; $display("FAIL again_addr: got %h want 123456", f_addr); end
    n_vec++; if (bus.line !== exp_line(24'h123456)) begin n_err++; $display("FAIL again_line: got %h want %h", bus.line, exp_line(24'h123456)); end
    n_vec++; if (f_oe_err !== 0) begin n_err++; $display("FAIL lane_enables: got %0d bad cycles want 0", f_oe_err); end
  endtask

  task automatic test_ignore_rd();
    int ndone, dc, bd, late_ce;
    bus.addr = 24'h000010; bus.xip_en = 1'b1; bus.rd = 1'b1;
    @(posedge clk); #1;
    bus.rd = 1'b0;
    ndone = 0; dc = -1; bd = -1; late_ce = 0;
    for (int k = 1; k <= 150; k++) begin
      if (bus.done === 1'b1) begin ndone++; if (dc < 0) dc = k; end
      if (bd < 0 && bus.busy === 1'b0) bd = k;
      if (dc >= 0 && ce_n1 === 1'b0) late_ce++;
      // cycle 60 is inside DATA, cycle 90 is the second GAP cycle
      if (k == 60 || k == 90) begin
        bus.addr = 24'hFFFFF0; bus.xip_en = 1'b0; bus.rd = 1'b1;
      end else begin
        bus.rd = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.rd = 1'b0;
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    n_vec++; if (dc !== 89) begin n_err++; $display("FAIL ignore_done_cycle: got %0d want 89", dc); end
    n_vec++; if (bd !== 91) begin n_err++; $display("FAIL ignore_busy_drop: got %0d want 91", bd); end
    n_vec++; if (late_ce !== 0) begin n_err++; $display("FAIL ignore_no_restart: got %0d low cycles want 0", late_ce); end
    n_vec++; if (bus.line !== exp_line(24'h000010)) begin n_err++; $display("FAIL ignore_line: got %h want %h", bus.line, exp_line(24'h000010)); end
    n_vec++; if (min_gap < 2) begin n_err++; $display("FAIL ce_gap: got %0d want >=2", min_gap); end
  endtask

  task automatic test_reset_mid();
    int dc, bd, c1, cr;
    logic saw_done;
    saw_done = 1'b0;
    bus.addr = 24'h000400; bus.xip_en = 1'b0; bus.rd = 1'b1;
    @(posedge clk); #1;
    bus.rd = 1'b0;
    repeat (39) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_vec++; if (ce_n1 !== 1'b1) begin n_err++; $display("FAIL rstmid_ce_n: got %b want 1", ce_n1); end
    n_vec++; if (sck1 !== 1'b0) begin n_err++; $display("FAIL rstmid_sck: got %b want 0", sck1); end
    n_vec++; if (douten1 !== 4'h0) begin n_err++; $display("FAIL rstmid_douten: got %h want 0", douten1); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0 || saw_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b/%b want 0/0", bus.done, saw_done); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_read(24'h000500, 1'b0, dc, bd, c1, cr);
    n_vec++; if (dc !== 105) begin n_err++; $display("FAIL rstmid_next_done: got %0d want 105", dc); end
    n_vec++; if (f_had_cmd !== 1'b1 || f_cmd !== 8'hEB) begin n_err++; $display("FAIL rstmid_next_cmd: got phase=%b cmd=%h want 1/eb", f_had_cmd, f_cmd); end
    n_vec++; if (bus.line !== exp_line(24'h000500)) begin n_err++; $display("FAIL rstmid_next_line: got %h want %h", bus.line, exp_line(24'h000500)); end
  endtask

  task automatic test_div2();
    int dc, sck_bad, dout_bad, ce_bad;
    logic [3:0]   prev;
    logic [255:0] exp2;
    exp2 = {64{4'h6}};
    dc = -1; sck_bad = 0; dout_bad = 0; ce_bad = 0;
    prev = dout2;
    bus2.addr = 24'h000000; bus2.xip_en = 1'b0; bus2.rd = 1'b1;
    @(posedge clk); #1;
    bus2.rd = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      if (dc < 0 && bus2.done === 1'b1) dc = k;
      if (k <= 344 && sck2 !== (((k - 1) % 4) >= 2)) sck_bad++;
      if (k <= 344 && ce_n2 !== 1'b0) ce_bad++;
      if (k <= 345 && dout2 !== prev && ((k - 1) % 4) != 0) dout_bad++;
      prev = dout2;
      if (bus2.busy === 1'b0) break;
      @(posedge clk); #1;
    end
    n_vec++; if (dc !== 345) begin n_err++; $display("FAIL div2_done_cycle: got %0d want 345", dc); end
    n_vec++; if (sck_bad !== 0) begin n_err++; $display("FAIL div2_sck_period: got %0d bad cycles want 0", sck_bad); end
    n_vec++; if (dout_bad !== 0) begin n_err++; $display("FAIL div2_dout_timing: got %0d bad changes want 0", dout_bad); end
    n_vec++; if (ce_bad !== 0) begin n_err++; $display("FAIL div2_ce_low: got %0d bad cycles want 0", ce_bad); end
    n_vec++; if (bus2.line !== exp2) begin n_err++; $display("FAIL div2_line: got %h want %h", bus2.line, exp2); end
  endtask

  initial begin
    bus.addr = 24'h000000; bus.rd = 1'b0; bus.xip_en = 1'b0;
    bus2.addr = 24'h000000; bus2.rd = 1'b0; bus2.xip_en = 1'b0;
    test_reset();
    test_first_read();
    test_xip_read();
    test_xip_exit();
    test_full_cmd_again();
    test_ignore_rd();
    test_reset_mid();
    test_div2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
